crc16_encode: RTL and testbench
===============================

CRC16_ENCODE -- requirements
Module: crc16_encode

Interface
REQ-001 SHALL have parameter PID_LEN, default 8, number of leading PID bits passed through and excluded from the CRC.
REQ-002 SHALL have parameter MAX_DATA_BITS, default 64, maximum number of CRC-covered data bits per packet.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports: clock  input  1  rising-edge clock; reset_n  input  1  async active-low reset.
REQ-004 SHALL have ports: start  input  1  one-cycle pulse, begins a packet (accepted only in IDLE).
REQ-005 SHALL have ports: in_bit  input  1  serial packet bit, LSB-first; in_valid  input  1  in_bit present; in_last  input  1  qualifies the final data bit.
REQ-006 SHALL have ports: in_ready  output  1  bit accepted this cycle when in_valid && in_ready.
REQ-007 SHALL have ports: out_bit  output  1  serial bit to the bit stuffer; out_valid  output  1  out_bit present; out_ready  input  1  downstream accepts out_bit (low = stuff stall).
REQ-008 SHALL have ports: busy  output  1  packet in progress; done  output  1  one-cycle pulse at packet end; overflow  output  1  one-cycle pulse when the data length was truncated.

Function
REQ-009 SHALL implement the CRC over polynomial x^16+x^15+x^2+1 as a 16-bit Galois LFSR initialised to 16'hFFFF: fb = bit ^ crc[15]; crc[0] = fb; crc[2] = crc[1]^fb; crc[15] = crc[14]^fb; all other bits shift up by one.
REQ-010 SHALL use the FSM states IDLE, PID, DATA and FLUSH.
REQ-011 In IDLE, a start pulse SHALL load crc = 16'hFFFF, clear all counters and move to PID on the next cycle; in_ready = 0 and out_valid = 0 in IDLE.
REQ-012 In PID and DATA: out_bit = in_bit, out_valid = in_valid and in_ready = out_ready, all combinationally, giving zero-cycle pass-through.
REQ-013 PID: after PID_LEN accepted bits, the FSM SHALL move to DATA; the CRC SHALL NOT update; in_last is ignored.
REQ-014 DATA: each accepted bit SHALL update the CRC and increment data_cnt.
REQ-015 DATA: an accepted bit with in_last = 1, or the MAX_DATA_BITS-th accepted bit, SHALL move the FSM to FLUSH on the next cycle.
REQ-016 If data_cnt reaches MAX_DATA_BITS without in_last, overflow SHALL pulse with the transition to FLUSH; further input is not accepted.
REQ-017 A packet with zero data bits is legal: in_last asserted on the final PID bit SHALL go directly to FLUSH (zero-length DATA packet).
REQ-018 FLUSH: in_ready = 0, out_valid = 1, and out_bit = ~crc[15 - flush_cnt], sent MSB first and complemented; flush_cnt (4 bit) increments on each out_ready cycle.
REQ-019 FLUSH: acceptance of the 16th CRC bit (flush_cnt = 15 && out_ready) SHALL return the FSM to IDLE and pulse done in that same cycle.
REQ-020 out_ready = 0 SHALL freeze the state, CRC and counters; out_bit SHALL stay stable while out_valid = 1.
REQ-021 in_valid = 0 in PID or DATA SHALL be a gap: no state change, no CRC update.
REQ-022 start while busy SHALL be ignored.
REQ-023 busy = 1 in every state except IDLE.
REQ-024 All bit counters SHALL be sized to their maximum value (PID_LEN, MAX_DATA_BITS, 16) and never wrap within a packet.

Reset
REQ-025 Asserting reset_n low at any time, including mid-packet, SHALL force IDLE and crc = 16'hFFFF, clear all counters, and drive in_ready = 0, out_valid = 0, out_bit = 0, busy = 0, done = 0 and overflow = 0.
REQ-026 After reset release, the next packet SHALL start only on a new start pulse; no partial CRC is emitted.

Structure
REQ-027 The shared USB package SHALL hold the state enum, CRC16_INIT = 16'hFFFF, CRC16_RESIDUE = 16'h800D, CRC16_LEN = 16 and PID_LEN = 8.
REQ-028 The LFSR SHALL be one sub-module crc16_lfsr (ports: clock, reset_n, init, shift, bit_in, crc[15:0]), which the receive-side checker also uses.

Verification
REQ-029 PID 8'hC3, zero data bits, out_ready = 1 -> PID bits then 16 CRC bits all 0; done pulses on the 24th output bit.
REQ-030 PID 8'hC3, data 8'h00 8'h01 8'h02 8'h03 -> 56 output bits; the CRC field matches a bitwise reference model, and feeding the 48 post-PID output bits into crc16_lfsr (init FFFF) leaves residue 16'h800D.
REQ-031 Same packet with out_ready randomly low 30% of cycles -> identical output bit sequence, out_bit stable during each stall, in_ready = 0 during each stall.
REQ-032 Drive 70 data bits without in_last -> 64 bits accepted, overflow pulses once, CRC covers exactly 64 bits, and the remaining input is held off (in_ready = 0).
REQ-033 reset_n low during FLUSH bit 7 -> next cycle busy = 0, out_valid = 0; a following packet with 8'h00 data produces a correct CRC and a correct residue.
REQ-034 start asserted during DATA and on the same cycle as done -> ignored, output unchanged; a start one cycle after done begins a new packet normally.

Source files
------------

// File: rtl/crc16_encode_pkg.sv
// Shared definitions for the USB CRC16 encoder and its receive-side checker.
package crc16_encode_pkg;
  typedef enum logic [1:0] {IDLE, PID, DATA, FLUSH} state_t;

  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam int          CRC16_LEN     = 16;
  localparam int          PID_LEN       = 8;
endpackage

// File: rtl/crc16_encode_if.sv
// Serial packet handshake between the bit source, the CRC16 encoder and the bit stuffer.
interface crc16_encode_if;
  logic start;
  logic in_bit;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  logic overflow;

  modport master (
    output start, in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_bit, out_valid, busy, done, overflow
  );

  modport slave (
    input  start, in_bit, in_valid, in_last, out_ready,
    output in_ready, out_bit, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/crc16_lfsr.sv
// Galois LFSR for x^16+x^15+x^2+1, shared by the encoder and the receive-side checker.
module crc16_lfsr
  import crc16_encode_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        init,
  input  logic        shift,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic fb;

  assign fb = bit_in ^ crc[15];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   crc <= CRC16_INIT;
    else if (init)  crc <= CRC16_INIT;
    else if (shift) crc <= {crc[14] ^ fb, crc[13:2], crc[1] ^ fb, crc[0], fb};
  end
endmodule

// File: rtl/crc16_encode.sv
// USB CRC16 encoder: passes PID and data bits through unchanged, then appends the complemented CRC MSB first.
module crc16_encode #(
  parameter int PID_LEN       = crc16_encode_pkg::PID_LEN,
  parameter int MAX_DATA_BITS = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  crc16_encode_if.slave  bus
);
  import crc16_encode_pkg::*;

  localparam int PCW = $clog2(PID_LEN + 1);
  localparam int DCW = $clog2(MAX_DATA_BITS + 1);

  state_t          state, state_nx;
  logic [PCW-1:0]  pid_cnt;
  logic [DCW-1:0]  data_cnt;
  logic [3:0]      flush_cnt;
  logic [15:0]     crc;
  logic            acc, crc_init, crc_shift;
  logic            pid_end, data_end;

  assign acc      = bus.in_valid && bus.out_ready;
  assign pid_end  = (pid_cnt == PCW'(PID_LEN - 1));
  assign data_end = (data_cnt == DCW'(MAX_DATA_BITS - 1));
  assign bus.busy = (state != IDLE);

  crc16_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (crc_init),
    .shift   (crc_shift),
    .bit_in  (bus.in_bit),
    .crc     (crc)
  );

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.done      = 1'b0;
    bus.overflow  = 1'b0;
    crc_init      = 1'b0;
    crc_shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = PID;
          crc_init = 1'b1;
        end
      end
      PID: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = bus.in_valid;
        bus.out_bit   = bus.in_bit;
        // in_last only matters on the final PID bit: that is the zero-length packet
        if (acc && pid_end) state_nx = bus.in_last ? FLUSH : DATA;
      end
      DATA: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = bus.in_valid;
        bus.out_bit   = bus.in_bit;
        if (acc) begin
          crc_shift    = 1'b1;
          bus.overflow = data_end && !bus.in_last;
          if (bus.in_last || data_end) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        bus.out_valid = 1'b1;
        bus.out_bit   = ~crc[4'd15 - flush_cnt];
        if (bus.out_ready && flush_cnt == 4'd15) begin
          state_nx = IDLE;
          bus.done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pid_cnt   <= '0;
      data_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.start) begin
          pid_cnt   <= '0;
          data_cnt  <= '0;
          flush_cnt <= '0;
        end
        PID:   if (acc) pid_cnt <= pid_cnt + 1'b1;
        DATA:  if (acc) data_cnt <= data_cnt + 1'b1;
        FLUSH: if (bus.out_ready) flush_cnt <= flush_cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crc16_encode.sv
// Directed bench for crc16_encode: scoreboard of expected serial output plus residue check on the wire bits.
module tb_crc16_encode;
  import crc16_encode_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  crc16_encode_if bus();

  crc16_encode #(.PID_LEN(8), .MAX_DATA_BITS(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic        res_init, res_shift, res_bit;
  logic [15:0] res_crc;

  crc16_lfsr chk (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (res_init),
    .shift   (res_shift),
    .bit_in  (res_bit),
    .crc     (res_crc)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit got_q[$];
  bit stall_mode = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_bit   = 1'b0;

  // Reference: shift left, xor in the polynomial when the outgoing bit differs from the input
  function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (prev_stall && bus.out_valid) check("stall_hold", bus.out_bit, prev_bit);
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_bit);
        check("out_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_bit", bus.out_bit, exp_q.pop_front());
      end
      if (bus.done) check("done_on_last_bit", exp_q.size(), 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bit   = bus.out_bit;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_packet(input logic [7:0] pid, input bit data[$], input bit use_last,
                            input int abort_at, input int start_mid, input bit start_on_done);
    bit bits[$];
    logic [15:0] c;
    int n_data, nacc, ocnt, ovf, dn, idx, cyc;
    bit acc;
    for (int i = 0; i < 8; i++) bits.push_back(pid[i]);
    foreach (data[i]) bits.push_back(data[i]);
    n_data = (!use_last && data.size() > 64) ? 64 : data.size();
    c = 16'hFFFF;
    for (int i = 0; i < 8 + n_data; i++) exp_q.push_back(bits[i]);
    for (int i = 0; i < n_data; i++) c = crc_step(c, data[i]);
    for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
    got_q.delete();

    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);

    idx = 0; nacc = 0; ocnt = 0; ovf = 0; dn = 0; cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = bits[0];
    bus.in_last  = use_last && bits.size() == 1;
    while (dn == 0 && cyc < 2000) begin
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      if (bus.overflow) ovf++;
      if (bus.done) dn++;
      if (abort_at >= 0 && bus.out_valid && ocnt == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_busy",      bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_bit",   bus.out_bit, 0);
        check("rst_done",      bus.done, 0);
        check("rst_overflow",  bus.overflow, 0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        return;
      end
      if (bus.out_valid && bus.out_ready) ocnt++;
      if (start_on_done && bus.done) bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (start_mid >= 0 && idx == start_mid && acc) bus.start = 1'b1;
      if (acc) begin
        nacc++;
        idx++;
        if (idx < bits.size()) begin
          bus.in_bit  = bits[idx];
          bus.in_last = use_last && idx == bits.size() - 1;
        end else begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
        end
      end
      bus.out_ready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
    check("done_seen",       dn, 1);
    check("accepted_bits",   nacc, 8 + n_data);
    check("output_bits",     ocnt, 8 + n_data + 16);
    check("overflow_pulses", ovf, (!use_last && data.size() >= 64) ? 1 : 0);
    if (start_on_done) check("start_on_done_ignored", bus.busy, 0);
  endtask

  task automatic check_residue(input string tag);
    bus.out_ready = 1'b1;
    res_init = 1'b1;
    @(posedge clock); #1;
    res_init  = 1'b0;
    res_shift = 1'b1;
    for (int i = 8; i < got_q.size(); i++) begin
      res_bit = got_q[i];
      @(posedge clock); #1;
    end
    res_shift = 1'b0;
    check(tag, res_crc, 16'h800D);
  endtask

  initial begin
    bit d0[$], d4[$], dz[$], d70[$];
    logic [7:0] bv;
    bus.start = 1'b0; bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    res_init = 1'b0; res_shift = 1'b0; res_bit = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy",      bus.busy, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready",  bus.in_ready, 0);
    check("reset_out_bit",   bus.out_bit, 0);
    check("reset_done",      bus.done, 0);
    check("reset_overflow",  bus.overflow, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("idle_busy", bus.busy, 0);

    // zero-length data packet: CRC field is ~FFFF, all zeros
    run_packet(8'hC3, d0, 1'b1, -1, -1, 1'b0);
    check_residue("residue_zero_len");

    for (int b = 0; b < 4; b++) begin
      bv = 8'(b);
      for (int i = 0; i < 8; i++) d4.push_back(bv[i]);
    end
    run_packet(8'hC3, d4, 1'b1, -1, -1, 1'b0);
    check_residue("residue_4byte");

    stall_mode = 1'b1;
    run_packet(8'hC3, d4, 1'b1, -1, -1, 1'b0);
    stall_mode = 1'b0;
    check_residue("residue_stall");

    for (int i = 0; i < 70; i++) d70.push_back(1'($urandom_range(0, 1)));
    run_packet(8'hC3, d70, 1'b0, -1, -1, 1'b0);
    check_residue("residue_overflow");

    // reset while the 8th CRC bit (output index 16 + 7) is on the wire
    for (int i = 0; i < 8; i++) dz.push_back(1'b0);
    run_packet(8'hC3, dz, 1'b1, 23, -1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("post_rst_no_output", bus.out_valid, 0);
    check("post_rst_idle",      bus.busy, 0);
    run_packet(8'hC3, dz, 1'b1, -1, -1, 1'b0);
    check_residue("residue_after_reset");

    run_packet(8'hC3, d4, 1'b1, -1, 10, 1'b1);
    run_packet(8'h5A, dz, 1'b1, -1, -1, 1'b0);
    check_residue("residue_back_to_back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
